// File: rtl/multicycle_core_pkg.sv
// Shared decode constants, state/ALU/trap enums and the funct3-to-ALU mapping
// for the multi-cycle RV32I core.
package multicycle_core_pkg;

  localparam logic [6:0] CLASS_LUI      = 7'b0110111;
  localparam logic [6:0] CLASS_AUIPC    = 7'b0010111;
  localparam logic [6:0] CLASS_JAL      = 7'b1101111;
  localparam logic [6:0] CLASS_JALR     = 7'b1100111;
  localparam logic [6:0] CLASS_BRANCH   = 7'b1100011;
  localparam logic [6:0] CLASS_LOAD     = 7'b0000011;
  localparam logic [6:0] CLASS_STORE    = 7'b0100011;
  localparam logic [6:0] CLASS_OP_IMM   = 7'b0010011;
  localparam logic [6:0] CLASS_OP       = 7'b0110011;
  localparam logic [6:0] CLASS_MISC_MEM = 7'b0001111;
  localparam logic [6:0] CLASS_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALT
  } core_state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    TRAP_NONE              = 2'd0,
    TRAP_ILLEGAL           = 2'd1,
    TRAP_MISALIGNED_MEM    = 2'd2,
    TRAP_MISALIGNED_TARGET = 2'd3
  } trap_cause_e;

  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational RV32I ALU; also exposes compare flags on the raw operands
// so branch resolution shares the operand muxes.
module rv_alu
  import multicycle_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core_regfile.sv
// 32-entry integer register file: two asynchronous read ports, one write port,
// x0 reads as zero and ignores writes.
module regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (wen && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I core (no CSR) with valid/ready fetch and data ports;
// one instruction in flight, traps park the core in HALT until reset.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            n_rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted,
  output logic [1:0]      trap_cause
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("multicycle_core: XLEN must be 32");
  end

  core_state_e     state, state_nxt;
  trap_cause_e     cause_q, cause_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [31:0]     ir;

  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_eq, alu_lt, alu_ltu;

  logic            legal, is_load, is_store, is_jal, is_jalr, is_branch;
  logic            has_rd, br_taken, jump_taken, mem_misaligned;
  logic [XLEN-1:0] pc_plus4, br_target, jump_target, ea, load_data;
  logic            rd_wen;
  logic [XLEN-1:0] rd_wdata;
  logic            commit;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_load   = (opcode == CLASS_LOAD);
  assign is_store  = (opcode == CLASS_STORE);
  assign is_jal    = (opcode == CLASS_JAL);
  assign is_jalr   = (opcode == CLASS_JALR);
  assign is_branch = (opcode == CLASS_BRANCH);
  assign has_rd    = (opcode == CLASS_LUI) || (opcode == CLASS_AUIPC) || is_jal ||
                     is_jalr || (opcode == CLASS_OP) || (opcode == CLASS_OP_IMM);

  regfile #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .wen      (rd_wen),
    .waddr    (rd),
    .wdata    (rd_wdata)
  );

  // Operand selection and legality check; the ALU also forms ea and jump targets.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = rs1_val;
    alu_b  = imm_i;
    legal  = 1'b0;
    case (opcode)
      CLASS_LUI: begin
        legal = 1'b1;
        alu_a = '0;
        alu_b = imm_u;
      end
      CLASS_AUIPC: begin
        legal = 1'b1;
        alu_a = pc;
        alu_b = imm_u;
      end
      CLASS_JAL: begin
        legal = 1'b1;
        alu_a = pc;
        alu_b = imm_j;
      end
      CLASS_JALR:     legal = (f3 == 3'b000);
      CLASS_BRANCH: begin
        legal = (f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
        alu_b = rs2_val;
      end
      CLASS_LOAD:     legal = (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      CLASS_STORE: begin
        legal = (f3 inside {F3_SB, F3_SH, F3_SW});
        alu_b = imm_s;
      end
      CLASS_OP_IMM: begin
        alu_op = alu_op_from_f3(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
        else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                  legal = 1'b1;
      end
      CLASS_OP: begin
        alu_op = alu_op_from_f3(f3, f7[5]);
        alu_b  = rs2_val;
        legal  = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      CLASS_MISC_MEM: legal = (f3 == 3'b000);
      default:        legal = 1'b0;
    endcase
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = alu_eq;
      F3_BNE:  br_taken = !alu_eq;
      F3_BLT:  br_taken = alu_lt;
      F3_BGE:  br_taken = !alu_lt;
      F3_BLTU: br_taken = alu_ltu;
      F3_BGEU: br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4    = pc + XLEN'(4);
  assign br_target   = pc + imm_b;
  assign jump_taken  = is_jal || is_jalr || (is_branch && br_taken);
  assign jump_target = is_jal  ? alu_result :
                       is_jalr ? {alu_result[XLEN-1:1], 1'b0} : br_target;

  // ir and the source registers are frozen during MEM, so ea is re-derived each cycle.
  assign ea = alu_result;
  always_comb begin
    mem_misaligned = 1'b0;
    case (f3[1:0])
      2'b10:   mem_misaligned = (ea[1:0] != 2'b00);
      2'b01:   mem_misaligned = ea[0];
      default: mem_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    load_data = dmem_rdata;
    case (f3)
      F3_LB:  load_data = {{(XLEN-8){dmem_rdata[{ea[1:0], 3'b000} + 5'd7]}},
                           dmem_rdata[{ea[1:0], 3'b000} +: 8]};
      F3_LBU: load_data = {{(XLEN-8){1'b0}}, dmem_rdata[{ea[1:0], 3'b000} +: 8]};
      F3_LH:  load_data = ea[1] ? {{(XLEN-16){dmem_rdata[31]}}, dmem_rdata[31:16]}
                                : {{(XLEN-16){dmem_rdata[15]}}, dmem_rdata[15:0]};
      F3_LHU: load_data = ea[1] ? {{(XLEN-16){1'b0}}, dmem_rdata[31:16]}
                                : {{(XLEN-16){1'b0}}, dmem_rdata[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_wdata = rs2_val;
    dmem_wstrb = 4'b0000;
    case (f3[1:0])
      2'b00: begin
        dmem_wdata = {4{rs2_val[7:0]}};
        dmem_wstrb = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{rs2_val[15:0]}};
        dmem_wstrb = 4'b0011 << ea[1:0];
      end
      default: dmem_wstrb = 4'b1111;
    endcase
    if (!is_store) dmem_wstrb = 4'b0000;
  end

  assign dmem_we   = is_store;
  assign dmem_addr = {ea[XLEN-1:2], 2'b00};
  assign imem_addr = pc;
  assign imem_req  = n_rst && (state == FETCH);
  assign dmem_req  = n_rst && (state == MEM);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cause_nxt = cause_q;
    commit    = 1'b0;
    rd_wdata  = alu_result;
    rd_wen    = 1'b0;
    case (state)
      FETCH: if (imem_ready) state_nxt = EXEC;
      EXEC: begin
        if (!legal) begin
          state_nxt = HALT;
          cause_nxt = TRAP_ILLEGAL;
        end else if ((is_load || is_store) && mem_misaligned) begin
          state_nxt = HALT;
          cause_nxt = TRAP_MISALIGNED_MEM;
        end else if (is_load || is_store) begin
          state_nxt = MEM;
        end else if (jump_taken && jump_target[1]) begin
          state_nxt = HALT;
          cause_nxt = TRAP_MISALIGNED_TARGET;
        end else begin
          state_nxt = FETCH;
          pc_nxt    = jump_taken ? jump_target : pc_plus4;
          commit    = 1'b1;
          rd_wen    = has_rd;
          rd_wdata  = (is_jal || is_jalr) ? pc_plus4 : alu_result;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          state_nxt = FETCH;
          pc_nxt    = pc_plus4;
          commit    = 1'b1;
          rd_wen    = is_load;
          rd_wdata  = load_data;
        end
      end
      default: state_nxt = HALT;
    endcase
    if (!n_rst) begin
      commit = 1'b0;
      rd_wen = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= FETCH;
      pc      <= RESET_VECTOR;
      cause_q <= TRAP_NONE;
      ir      <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cause_q <= cause_nxt;
      if ((state == FETCH) && imem_ready) ir <= imem_rdata;
    end
  end

  assign retire     = commit;
  assign halted     = (state == HALT);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small hand-assembled programs against
// a wait-state-capable memory model, with hand-computed expectations.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        retire, halted;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  multicycle_core #(.XLEN(32), .RESET_VECTOR(32'h0)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .halted     (halted),
    .trap_cause (trap_cause)
  );

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int unsigned dmem_wait = 0;
  int unsigned dwait_cnt = 0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          dreq_cycles = 0;
  int          ret_cyc[$];
  logic [31:0] fetch_log[$];
  logic [31:0] st_addr[$];
  logic [31:0] st_wdata[$];
  logic [3:0]  st_wstrb[$];
  logic        dpend = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  logic        p_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  // Memory responder: ready is presented at the negedge so it is valid
  // combinationally for the following posedge.
  always @(negedge clk) begin
    imem_ready = imem_req;
    imem_rdata = imem_req ? imem[imem_addr[9:2]] : 32'h0;
    if (dmem_req) begin
      if (dwait_cnt < dmem_wait) begin
        dwait_cnt++;
        dmem_ready = 1'b0;
      end else begin
        dwait_cnt  = 0;
        dmem_ready = 1'b1;
        if (dmem_we) begin
          for (int b = 0; b < 4; b++)
            if (dmem_wstrb[b]) dmem[dmem_addr[9:2]][b*8 +: 8] = dmem_wdata[b*8 +: 8];
          st_addr.push_back(dmem_addr);
          st_wdata.push_back(dmem_wdata);
          st_wstrb.push_back(dmem_wstrb);
        end else begin
          dmem_rdata = dmem[dmem_addr[9:2]];
        end
      end
    end else begin
      dwait_cnt  = 0;
      dmem_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!n_rst) begin
      dpend = 1'b0;
    end else begin
      cyc++;
      if (retire) ret_cyc.push_back(cyc);
      if (imem_req && imem_ready) fetch_log.push_back(imem_addr);
      if (dmem_req) begin
        dreq_cycles++;
        if (dpend) begin
          check("dmem_addr_hold", dmem_addr, p_addr);
          check("dmem_wdata_hold", dmem_wdata, p_wdata);
          check("dmem_wstrb_hold", {28'h0, dmem_wstrb}, {28'h0, p_wstrb});
          check("dmem_we_hold", {31'h0, dmem_we}, {31'h0, p_we});
        end
        dpend   = !dmem_ready;
        p_addr  = dmem_addr;
        p_wdata = dmem_wdata;
        p_wstrb = dmem_wstrb;
        p_we    = dmem_we;
      end else begin
        dpend = 1'b0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = ECALL;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic reset_core(input int unsigned wait_states);
    n_rst = 1'b0;
    dmem_wait = wait_states;
    repeat (2) @(posedge clk);
    cyc = 0;
    dreq_cycles = 0;
    ret_cyc.delete();
    fetch_log.delete();
    st_addr.delete();
    st_wdata.delete();
    st_wstrb.delete();
    #1 n_rst = 1'b1;
  endtask

  task automatic run_until_halt(input string tag, input int bound);
    int k;
    k = 0;
    while (!halted && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_halted"}, {31'h0, halted}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("rst_retire", {31'h0, retire}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_trap_cause", {30'h0, trap_cause}, 32'h0);
    check("rst_pc", imem_addr, 32'h0);

    // T1: addi/addi/sw, then ecall; 2-cycle ALU and 3-cycle store cadence
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'h005);
    imem[1] = addi(5'd2, 5'd1, 12'hFF9);
    imem[2] = enc_s(12'h040, 5'd2, 5'd0, 3'b010);
    imem[3] = ECALL;
    reset_core(0);
    run_until_halt("t1", 100);
    check("t1_sw_x2", dmem[16], 32'hFFFF_FFFE);
    check("t1_retires", ret_cyc.size(), 32'd3);
    if (ret_cyc.size() == 3) begin
      check("t1_first_retire_cyc", ret_cyc[0], 32'd2);
      check("t1_alu_gap", ret_cyc[1] - ret_cyc[0], 32'd2);
      check("t1_store_gap", ret_cyc[2] - ret_cyc[1], 32'd3);
    end
    check("t1_ecall_cause", {30'h0, trap_cause}, 32'd1);
    check("t1_ecall_pc", imem_addr, 32'h0000_000C);

    // T2: word store then lb/lbu of the top byte with 3 wait-states
    clear_mem();
    imem[0] = lui(5'd5, 20'hA1B2C);
    imem[1] = addi(5'd5, 5'd5, 12'h3D4);
    imem[2] = addi(5'd6, 5'd0, 12'h080);
    imem[3] = enc_s(12'h000, 5'd5, 5'd6, 3'b010);
    imem[4] = enc_i(12'h003, 5'd6, 3'b000, 5'd7, 7'h03);
    imem[5] = enc_i(12'h003, 5'd6, 3'b100, 5'd8, 7'h03);
    imem[6] = enc_s(12'h004, 5'd7, 5'd6, 3'b010);
    imem[7] = enc_s(12'h008, 5'd8, 5'd6, 3'b010);
    imem[8] = ECALL;
    reset_core(3);
    run_until_halt("t2", 300);
    check("t2_sw_word", dmem[32], 32'hA1B2_C3D4);
    check("t2_lb", dmem[33], 32'hFFFF_FFA1);
    check("t2_lbu", dmem[34], 32'h0000_00A1);
    check("t2_dreq_cycles", dreq_cycles, 32'd20);

    // T3: bne taken, beq not taken, then jalr to a half-word-aligned target
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'h001);
    imem[1] = enc_b(13'd8, 5'd0, 5'd1, 3'b001);
    imem[2] = ECALL;
    imem[3] = enc_b(13'd8, 5'd0, 5'd1, 3'b000);
    imem[4] = addi(5'd2, 5'd0, 12'h100);
    imem[5] = enc_i(12'h003, 5'd2, 3'b000, 5'd1, 7'h67);
    reset_core(0);
    run_until_halt("t3", 100);
    check("t3_fetch_count", fetch_log.size(), 32'd5);
    if (fetch_log.size() == 5) begin
      check("t3_fetch0", fetch_log[0], 32'h00);
      check("t3_fetch1", fetch_log[1], 32'h04);
      check("t3_fetch2", fetch_log[2], 32'h0C);
      check("t3_fetch3", fetch_log[3], 32'h10);
      check("t3_fetch4", fetch_log[4], 32'h14);
    end
    check("t3_cause", {30'h0, trap_cause}, 32'd3);
    check("t3_fault_pc", imem_addr, 32'h14);
    check("t3_x1_kept", u_dut.u_rf.regs[1], 32'h1);

    // T4: misaligned lw never reaches the bus; then an illegal funct7
    clear_mem();
    imem[0] = addi(5'd3, 5'd0, 12'h100);
    imem[1] = enc_i(12'h002, 5'd3, 3'b010, 5'd4, 7'h03);
    reset_core(0);
    run_until_halt("t4a", 100);
    check("t4a_cause", {30'h0, trap_cause}, 32'd2);
    check("t4a_fault_pc", imem_addr, 32'h4);
    check("t4a_no_dreq", dreq_cycles, 32'd0);

    clear_mem();
    imem[0] = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    reset_core(0);
    run_until_halt("t4b", 100);
    check("t4b_cause", {30'h0, trap_cause}, 32'd1);
    check("t4b_fault_pc", imem_addr, 32'h0);
    check("t4b_no_retire", ret_cyc.size(), 32'd0);

    // T5: reset asserted mid-way through a stalled load
    clear_mem();
    imem[0] = addi(5'd6, 5'd0, 12'h080);
    imem[1] = enc_i(12'h000, 5'd6, 3'b010, 5'd7, 7'h03);
    reset_core(50);
    begin
      int k;
      k = 0;
      while (!dmem_req && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("t5_dreq_seen", {31'h0, dmem_req}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("t5_dreq_waiting", {31'h0, dmem_req}, 32'h1);
    #2 n_rst = 1'b0;
    #1;
    check("t5_dreq_drop", {31'h0, dmem_req}, 32'h0);
    check("t5_ireq_drop", {31'h0, imem_req}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_halted", {31'h0, halted}, 32'h0);
    n_rst = 1'b1;
    #1;
    check("t5_refetch_req", {31'h0, imem_req}, 32'h1);
    check("t5_refetch_pc", imem_addr, 32'h0);

    // T6: sh at ea=2 and sb at ea=1 with lane replication
    clear_mem();
    imem[0] = lui(5'd5, 20'h00001);
    imem[1] = addi(5'd5, 5'd5, 12'h234);
    imem[2] = enc_s(12'h002, 5'd5, 5'd0, 3'b001);
    imem[3] = enc_s(12'h001, 5'd5, 5'd0, 3'b000);
    imem[4] = ECALL;
    reset_core(0);
    run_until_halt("t6", 100);
    check("t6_store_count", st_wstrb.size(), 32'd2);
    if (st_wstrb.size() == 2) begin
      check("t6_sh_wstrb", {28'h0, st_wstrb[0]}, 32'h0000_000C);
      check("t6_sh_wdata", st_wdata[0], 32'h1234_1234);
      check("t6_sh_addr", st_addr[0], 32'h0);
      check("t6_sb_wstrb", {28'h0, st_wstrb[1]}, 32'h0000_0002);
      check("t6_sb_wdata", st_wdata[1], 32'h3434_3434);
    end
    check("t6_word0", dmem[0], 32'h1234_3400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
